// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts one
// command byte out on device clock falls and checks the device's ack bit.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1600,
    parameter int TIMEOUT_CYCLES = 32000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE,
    input  logic [7:0] TX_DATA,
    input  logic       TX_START,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR
);
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INH_START = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t                state;
    logic [FILTER_LEN-1:0] clk_shift;
    logic                  clk_filt;
    logic                  clk_fall;
    logic                  data_q;
    logic [9:0]            frame;
    logic [3:0]            bit_idx;
    logic [CNT_W-1:0]      cnt;
    logic                  tracking;
    logic                  timed_out;

    // The filtered clock only changes once the whole window agrees, so short glitches vanish.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_shift <= '1;
            clk_filt  <= 1'b1;
            clk_fall  <= 1'b0;
            data_q    <= 1'b1;
        end else begin
            clk_shift <= {clk_shift[FILTER_LEN-2:0], PS2_CLK};
            data_q    <= PS2_DATA;
            clk_fall  <= 1'b0;
            if (&clk_shift) begin
                clk_filt <= 1'b1;
            end else if (~|clk_shift) begin
                clk_filt <= 1'b0;
                clk_fall <= clk_filt;
            end
        end
    end

    assign tracking  = state inside {REQ, SEND, ACK, WAIT_IDLE};
    assign timed_out = (cnt == TMO_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            PS2_CLK_OE  <= 1'b0;
            PS2_DATA_OE <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            ERROR       <= 1'b0;
            frame       <= '0;
            bit_idx     <= '0;
            cnt         <= '0;
        end else begin
            // NOTE: DONE/ERROR default low every cycle so any assignment below is a single-cycle pulse.
            DONE  <= 1'b0;
            ERROR <= 1'b0;
            if (tracking && timed_out && !clk_fall) begin
                state       <= IDLE;
                PS2_CLK_OE  <= 1'b0;
                PS2_DATA_OE <= 1'b0;
                BUSY        <= 1'b0;
                ERROR       <= 1'b1;
                cnt         <= '0;
            end else begin
                if (tracking) cnt <= clk_fall ? '0 : cnt + 1'b1;
                case (state)
                    IDLE: begin
                        if (TX_START) begin
                            frame      <= {1'b1, ~^TX_DATA, TX_DATA};
                            PS2_CLK_OE <= 1'b1;
                            BUSY       <= 1'b1;
                            cnt        <= '0;
                            state      <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        cnt <= cnt + 1'b1;
                        // Start bit goes down while the clock is still held, one cycle before release.
                        if (cnt == INH_START) PS2_DATA_OE <= 1'b1;
                        if (cnt == INH_LAST) begin
                            PS2_CLK_OE <= 1'b0;
                            cnt        <= '0;
                            state      <= REQ;
                        end
                    end
                    REQ: begin
                        if (clk_fall) begin
                            PS2_DATA_OE <= ~frame[0];
                            bit_idx     <= 4'd1;
                            state       <= SEND;
                        end
                    end
                    SEND: begin
                        if (clk_fall) begin
                            PS2_DATA_OE <= ~frame[bit_idx];
                            if (bit_idx == 4'd9) state <= ACK;
                            else bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    ACK: begin
                        if (clk_fall) begin
                            PS2_DATA_OE <= 1'b0;
                            if (data_q) begin
                                ERROR <= 1'b1;
                                BUSY  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                state <= WAIT_IDLE;
                            end
                        end
                    end
                    WAIT_IDLE: begin
                        if (clk_filt && data_q) begin
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host and
// the sampled bits and DONE/ERROR pulses are compared against a simple frame model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INHIBIT_CYCLES = 16;
    localparam int TIMEOUT_CYCLES = 200;
    localparam int FILTER_LEN     = 8;
    localparam int HALF           = 40;
    // Raw line edge to registered reaction: FILTER_LEN samples, one filter decision, one FSM edge.
    localparam int COND_LAT       = FILTER_LEN + 2;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       TX_START;
    logic [7:0] TX_DATA;
    logic       PS2_CLK_OE, PS2_DATA_OE, BUSY, DONE, ERROR;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    int cyc;
    int done_cnt, err_cnt, last_err_cyc, last_fall_cyc;
    int checks, errors;

    // Open-drain bus: either side pulling low wins.
    assign ps2_clk_line  = !(PS2_CLK_OE || dev_clk_low);
    assign ps2_data_line = !(PS2_DATA_OE || dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FILTER_LEN    (FILTER_LEN)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .PS2_CLK    (ps2_clk_line),
        .PS2_DATA   (ps2_data_line),
        .PS2_CLK_OE (PS2_CLK_OE),
        .PS2_DATA_OE(PS2_DATA_OE),
        .TX_DATA    (TX_DATA),
        .TX_START   (TX_START),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERROR      (ERROR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (DONE) done_cnt++;
        if (ERROR) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
    end

    // Expected wire order of the ten host-driven bits: data LSb first, odd parity, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic [9:0] f;
        f[7:0] = b;
        f[8]   = ($countones(b) % 2 == 0);
        f[9]   = 1'b1;
        return f;
    endfunction

    // Device side of one frame. stop_after>0: stop clocking after that fall and expect a timeout.
    // reset_after>0: pulse RESET in the high phase after that rise. The task returns after rise 11.
    task automatic run_frame(input logic [7:0] b, input bit ack_bit, input int stop_after,
                             input int reset_after, input bit mid_start, input bit glitch,
                             output logic [9:0] sampled);
        int n, hi, both, fall_cyc;
        sampled  = '0;
        TX_DATA  = b;
        TX_START = 1'b1;
        @(negedge CLK);
        TX_START = 1'b0;
        TX_DATA  = 8'($urandom);
        n = 0;
        while (!PS2_CLK_OE && n < 100) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n != 0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL accept: clk_oe after %0d cycles busy=%b, required 0 cycles busy=1", n, BUSY);
        end
        hi   = 0;
        both = 0;
        while (PS2_CLK_OE && hi < 1000) begin
            hi++;
            if (PS2_DATA_OE) both++;
            @(negedge CLK);
        end
        checks++;
        if (hi != INHIBIT_CYCLES || both != 1) begin
            errors++;
            $display("FAIL inhibit: clk_oe %0d cycles, start overlap %0d, required %0d and 1",
                     hi, both, INHIBIT_CYCLES);
        end
        checks++;
        if (ps2_data_line !== 1'b0) begin
            errors++;
            $display("FAIL start_bit: data line %b at clock release, required 0", ps2_data_line);
        end
        for (int f = 1; f <= 11; f++) begin
            if (glitch && (f == 1 || f == 6)) begin
                repeat (10) @(negedge CLK);
                dev_clk_low = 1'b1;
                repeat (3) @(negedge CLK);
                dev_clk_low = 1'b0;
                repeat (HALF - 13) @(negedge CLK);
            end else if (f == 11) begin
                repeat (HALF / 2) @(negedge CLK);
                dev_data_low = !ack_bit;
                repeat (HALF / 2) @(negedge CLK);
            end else begin
                repeat (HALF) @(negedge CLK);
            end
            dev_clk_low   = 1'b1;
            fall_cyc      = cyc;
            last_fall_cyc = cyc;
            if (f == stop_after) begin
                n = 0;
                while (!ERROR && n < 2 * TIMEOUT_CYCLES) begin
                    @(negedge CLK);
                    n++;
                end
                checks++;
                if (!ERROR || cyc - fall_cyc != TIMEOUT_CYCLES + COND_LAT) begin
                    errors++;
                    $display("FAIL timeout_latency: error=%b after %0d cycles, required 1 after %0d",
                             ERROR, cyc - fall_cyc, TIMEOUT_CYCLES + COND_LAT);
                end
                checks++;
                if (PS2_CLK_OE !== 1'b0 || PS2_DATA_OE !== 1'b0 || BUSY !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_release: clk_oe=%b data_oe=%b busy=%b, required 0 0 0",
                             PS2_CLK_OE, PS2_DATA_OE, BUSY);
                end
                dev_clk_low = 1'b0;
                return;
            end
            if (mid_start && f == 5) begin
                repeat (10) @(negedge CLK);
                TX_DATA  = 8'h00;
                TX_START = 1'b1;
                @(negedge CLK);
                TX_START = 1'b0;
                repeat (HALF - 11) @(negedge CLK);
            end else begin
                repeat (HALF) @(negedge CLK);
            end
            dev_clk_low = 1'b0;
            if (f <= 10) sampled[f-1] = ps2_data_line;
            if (f == 11) dev_data_low = 1'b0;
            if (f == reset_after) begin
                repeat (HALF / 2) @(negedge CLK);
                RESET = 1'b1;
                @(negedge CLK);
                RESET = 1'b0;
                checks++;
                if (PS2_CLK_OE !== 1'b0 || PS2_DATA_OE !== 1'b0 || BUSY !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_release: clk_oe=%b data_oe=%b busy=%b, required 0 0 0",
                             PS2_CLK_OE, PS2_DATA_OE, BUSY);
                end
                return;
            end
        end
    endtask

    task automatic wait_outcome(input int d0, input int e0);
        int n = 0;
        while (done_cnt + err_cnt == d0 + e0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        repeat (5) @(negedge CLK);
    endtask

    task automatic test_frame(input logic [7:0] b, input bit ack_bit, input bit glitch);
        logic [9:0] got, exp;
        int d0, e0;
        repeat (20) @(negedge CLK);
        d0 = done_cnt;
        e0 = err_cnt;
        run_frame(b, ack_bit, 0, 0, 1'b0, glitch, got);
        wait_outcome(d0, e0);
        exp = model_frame(b);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL frame_bits %02h: sampled %010b, required %010b", b, got, exp);
        end
        checks++;
        if (done_cnt - d0 != (ack_bit ? 0 : 1) || err_cnt - e0 != (ack_bit ? 1 : 0)) begin
            errors++;
            $display("FAIL outcome %02h ack=%0d: done %0d error %0d, required %0d %0d", b, ack_bit,
                     done_cnt - d0, err_cnt - e0, ack_bit ? 0 : 1, ack_bit ? 1 : 0);
        end
        checks++;
        if (BUSY !== 1'b0 || PS2_CLK_OE !== 1'b0 || PS2_DATA_OE !== 1'b0) begin
            errors++;
            $display("FAIL idle_after %02h: busy=%b clk_oe=%b data_oe=%b, required 0 0 0",
                     b, BUSY, PS2_CLK_OE, PS2_DATA_OE);
        end
    endtask

    task automatic test_reset();
        RESET    = 1'b1;
        TX_START = 1'b0;
        TX_DATA  = 8'h00;
        repeat (3) @(negedge CLK);
        checks++;
        if ({PS2_CLK_OE, PS2_DATA_OE, BUSY, DONE, ERROR} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state: outputs %05b, required 00000",
                     {PS2_CLK_OE, PS2_DATA_OE, BUSY, DONE, ERROR});
        end
        RESET = 1'b0;
        repeat (20) @(negedge CLK);
        checks++;
        if ({PS2_CLK_OE, PS2_DATA_OE, BUSY, DONE, ERROR} !== 5'b0) begin
            errors++;
            $display("FAIL idle_state: outputs %05b, required 00000",
                     {PS2_CLK_OE, PS2_DATA_OE, BUSY, DONE, ERROR});
        end
    endtask

    task automatic test_known_bytes();
        test_frame(8'hED, 1'b0, 1'b0);
        test_frame(8'hF4, 1'b0, 1'b0);
    endtask

    task automatic test_nack();
        test_frame(8'hFF, 1'b1, 1'b0);
        checks++;
        if (last_err_cyc - last_fall_cyc != COND_LAT) begin
            errors++;
            $display("FAIL nack_latency: error %0d cycles after fall 11, required %0d",
                     last_err_cyc - last_fall_cyc, COND_LAT);
        end
    endtask

    task automatic test_timeout();
        logic [9:0] got, exp;
        logic [7:0] b;
        int d0, e0;
        repeat (20) @(negedge CLK);
        b  = 8'($urandom);
        d0 = done_cnt;
        e0 = err_cnt;
        run_frame(b, 1'b0, 4, 0, 1'b0, 1'b0, got);
        repeat (50) @(negedge CLK);
        exp = model_frame(b);
        checks++;
        if (got[2:0] !== exp[2:0]) begin
            errors++;
            $display("FAIL timeout_bits %02h: sampled %03b, required %03b", b, got[2:0], exp[2:0]);
        end
        checks++;
        if (done_cnt - d0 != 0 || err_cnt - e0 != 1) begin
            errors++;
            $display("FAIL timeout_outcome: done %0d error %0d, required 0 1",
                     done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_ignore_start();
        logic [9:0] got, exp;
        int d0, e0;
        repeat (20) @(negedge CLK);
        d0 = done_cnt;
        e0 = err_cnt;
        run_frame(8'hA7, 1'b0, 0, 0, 1'b1, 1'b0, got);
        wait_outcome(d0, e0);
        repeat (100) @(negedge CLK);
        exp = model_frame(8'hA7);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL busy_start_bits: sampled %010b, required %010b", got, exp);
        end
        checks++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0 || PS2_CLK_OE !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_outcome: done %0d error %0d clk_oe=%b, required 1 0 0",
                     done_cnt - d0, err_cnt - e0, PS2_CLK_OE);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] got;
        int d0, e0;
        repeat (20) @(negedge CLK);
        d0 = done_cnt;
        e0 = err_cnt;
        run_frame(8'h3C, 1'b0, 0, 3, 1'b0, 1'b0, got);
        repeat (50) @(negedge CLK);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge CLK);
        dev_clk_low = 1'b0;
        repeat (50) @(negedge CLK);
        checks++;
        if (done_cnt != d0 || err_cnt != e0 || PS2_CLK_OE !== 1'b0 || PS2_DATA_OE !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiet: done %0d error %0d clk_oe=%b data_oe=%b, required 0 0 0 0",
                     done_cnt - d0, err_cnt - e0, PS2_CLK_OE, PS2_DATA_OE);
        end
        test_frame(8'hA5, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [9:0] got1, got2;
        logic [7:0] b1, b2;
        int d0, e0, n;
        repeat (20) @(negedge CLK);
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        d0 = done_cnt;
        e0 = err_cnt;
        run_frame(b1, 1'b0, 0, 0, 1'b0, 1'b0, got1);
        n = 0;
        while (!DONE && n < 200) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (!DONE || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: done=%b busy=%b, required 1 0", DONE, BUSY);
        end
        run_frame(b2, 1'b0, 0, 0, 1'b0, 1'b0, got2);
        wait_outcome(d0 + 1, e0);
        checks++;
        if (got1 !== model_frame(b1) || got2 !== model_frame(b2)) begin
            errors++;
            $display("FAIL b2b_bits: %010b %010b, required %010b %010b",
                     got1, got2, model_frame(b1), model_frame(b2));
        end
        checks++;
        if (done_cnt - d0 != 2 || err_cnt - e0 != 0) begin
            errors++;
            $display("FAIL b2b_outcome: done %0d error %0d, required 2 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            test_frame(8'($urandom), ($urandom_range(0, 2) == 0), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_known_bytes();
        test_nack();
        test_timeout();
        test_ignore_start();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete within 90000 cycles");
        $fatal(1, "watchdog expired");
    end
endmodule
